// File: rtl/dma_controller.sv
// -----------------------------------------------------------------------------
// dma_controller
//
// Copies a block of device data into data memory one 64-bit line (4 x 16-bit
// words) at a time. It shares the memory port with the CPU/D-cache and only
// drives the port while the arbiter grants the bus.
//
// Bus handshake: br is the request and bg is the grant. A line write runs only
// while br=1 and bg=1. bg is sampled on every rising edge. If bg is seen low
// during a write, the partial line is abandoned, mem_write_m drops on that
// edge, and the same line is retried from the start once bg returns. Lines
// that already completed are never written again.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   dma_start    command strobe, only honoured while idle
//   dma_addr     destination word address (bits [1:0] ignored)
//   dma_len      word count (bits [1:0] ignored, whole lines only)
//   bg           bus grant
//   dev_data     line supplied by the device for chunk dev_index
//   br           bus request
//   mem_write_m  memory write enable
//   mem_address  line base address of the current write
//   mem_data     write data, forced to 0 when not writing
//   dev_index    chunk index presented to the device
//   busy         high whenever not idle
//   dma_done     one-cycle completion pulse
//
// Optional feature macro: DMA_CYCLE_STEAL_EN. When defined, the bus is
// released for one cycle after every non-final line so that the CPU/D-cache
// can use it between lines.
//
// Debug visibility: the FSM state is held in state_q (type state_t).
// -----------------------------------------------------------------------------
module dma_controller #(
    parameter int ADDR_W      = 16,
    parameter int LEN_W       = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic              bg,
    input  logic [63:0]       dev_data,
    output logic              br,
    output logic              mem_write_m,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_data,
    output logic [LEN_W-3:0]  dev_index,
    output logic              busy,
    output logic              dma_done
);

    localparam int CHUNK_W = LEN_W - 2;
    localparam int LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [LAT_W-1:0]   LAT_ONE   = LAT_W'(1);
    localparam logic [CHUNK_W-1:0] CHUNK_ONE = CHUNK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE
`ifdef DMA_CYCLE_STEAL_EN
        , S_RELEASE
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CHUNK_W-1:0]  nchunks_q, nchunks_d;
    logic [CHUNK_W-1:0]  chunk_q, chunk_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic                br_q, br_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [CHUNK_W-1:0]  dev_index_q, dev_index_d;
    logic                busy_q, busy_d;
    logic                dma_done_q, dma_done_d;

    // Low address/length bits select within a line and are deliberately unused.
    logic                unused_low_bits;
    assign unused_low_bits = ^{dma_addr[1:0], dma_len[1:0]};

    // Next-state and bookkeeping.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        nchunks_d = nchunks_q;
        chunk_d   = chunk_q;
        lat_d     = lat_q;

        case (state_q)
            S_IDLE: begin
                if (dma_start) begin
                    base_d    = {dma_addr[ADDR_W-1:2], 2'b00};
                    nchunks_d = dma_len[LEN_W-1:2];
                    chunk_d   = '0;
                    lat_d     = '0;
                    state_d   = (dma_len[LEN_W-1:2] == '0) ? S_DONE : S_REQ;
                end
            end

            S_REQ: begin
                if (bg) begin
                    state_d = S_XFER;
                    lat_d   = '0;
                end
            end

            S_XFER: begin
                if (!bg) begin
                    // Grant lost: drop the partial line and retry it whole.
                    state_d = S_REQ;
                    lat_d   = '0;
                end else if (lat_q == LAT_LAST) begin
                    chunk_d = chunk_q + CHUNK_ONE;
                    lat_d   = '0;
                    if (chunk_q == nchunks_q - CHUNK_ONE) begin
                        state_d = S_DONE;
                    end else begin
`ifdef DMA_CYCLE_STEAL_EN
                        state_d = S_RELEASE;
`else
                        state_d = S_XFER;
`endif
                    end
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end

`ifdef DMA_CYCLE_STEAL_EN
            S_RELEASE: begin
                state_d = S_REQ;
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    always_comb begin
        br_d          = (state_d == S_REQ) || (state_d == S_XFER);
        mem_write_d   = (state_d == S_XFER);
        mem_address_d = '0;
        dev_index_d   = '0;
        if (state_d == S_XFER) begin
            // Line offset wraps modulo 2^ADDR_W with the address.
            mem_address_d = base_d + ADDR_W'({chunk_d, 2'b00});
            dev_index_d   = chunk_d;
        end
        busy_d     = (state_d != S_IDLE);
        dma_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            nchunks_q     <= '0;
            chunk_q       <= '0;
            lat_q         <= '0;
            br_q          <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            dev_index_q   <= '0;
            busy_q        <= 1'b0;
            dma_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            nchunks_q     <= nchunks_d;
            chunk_q       <= chunk_d;
            lat_q         <= lat_d;
            br_q          <= br_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            dev_index_q   <= dev_index_d;
            busy_q        <= busy_d;
            dma_done_q    <= dma_done_d;
        end
    end

    assign br          = br_q;
    assign mem_write_m = mem_write_q;
    assign mem_address = mem_address_q;
    assign dev_index   = dev_index_q;
    assign busy        = busy_q;
    assign dma_done    = dma_done_q;

    // The device presents the line for dev_index combinationally, so the
    // data is passed straight through and gated by the registered enable.
    assign mem_data = mem_write_q ? dev_data : 64'd0;

endmodule

// File: tb/tb_dma_controller.sv
module tb_dma_controller;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 16;
    localparam int L      = 4;
    localparam int IDX_W  = LEN_W - 2;
`ifdef DMA_CYCLE_STEAL_EN
    localparam int GAP = 2;  // RELEASE + REQ between lines
`else
    localparam int GAP = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              dma_start = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [LEN_W-1:0]  dma_len = '0;
    logic              bg = 1'b0;
    logic [63:0]       dev_data;
    logic              br, mem_write_m, busy, dma_done;
    logic [ADDR_W-1:0] mem_address;
    logic [63:0]       mem_data;
    logic [IDX_W-1:0]  dev_index;
    logic [63:0]       salt = 64'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_controller #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .dma_start(dma_start), .dma_addr(dma_addr),
        .dma_len(dma_len), .bg(bg), .dev_data(dev_data), .br(br),
        .mem_write_m(mem_write_m), .mem_address(mem_address), .mem_data(mem_data),
        .dev_index(dev_index), .busy(busy), .dma_done(dma_done)
    );

    function automatic logic [63:0] line_of(input logic [IDX_W-1:0] idx, input logic [63:0] s);
        line_of = {2'b10, idx, 16'hC0DE, 2'b01, idx, 16'(idx * 16'd7 + 16'd3)} ^ s;
    endfunction

    assign dev_data = line_of(dev_index, salt);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    // Expected lines in order: a line is committed after L consecutive write
    // cycles at its address with the grant present.
    logic [ADDR_W-1:0] exp_q[$];
    logic [IDX_W-1:0]  exp_idx_q[$];
    int run = 0;
    bit exp_drop = 0, exp_enter = 0, exp_gap = 0, exp_after_gap = 0;
    bit exp_next_write = 0, exp_done = 0, zero_pending = 0;
    int done_pulses = 0, commits = 0, done_cyc = 0;
    logic [ADDR_W-1:0] first_wr_addr = '0;
    bit first_wr_seen = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_idx_q.delete();
            run = 0;
            exp_drop = 0; exp_enter = 0; exp_gap = 0; exp_after_gap = 0;
            exp_next_write = 0; exp_done = 0; zero_pending = 0;
        end else begin
            if (exp_drop)       chk("drop_on_bg_loss", mem_write_m, 1'b0);
            if (exp_enter)      chk("xfer_after_grant", mem_write_m, 1'b1);
            if (exp_gap) begin
                chk("release_br", br, 1'b0);
                chk("release_mw", mem_write_m, 1'b0);
            end
            if (exp_after_gap)  chk("req_after_release", br, 1'b1);
            if (exp_next_write) chk("back_to_back", mem_write_m, 1'b1);
            chk("dma_done", dma_done, exp_done);
            if (exp_done) begin
                chk("done_br_low", br, 1'b0);
                chk("done_mw_low", mem_write_m, 1'b0);
            end
            if (dma_done) begin
                done_pulses++;
                done_cyc = cyc;
            end
            if (!busy) begin
                chk("idle_br", br, 1'b0);
                chk("idle_mw", mem_write_m, 1'b0);
            end

            exp_after_gap = exp_gap;
            exp_drop = 0; exp_enter = 0; exp_gap = 0; exp_next_write = 0;
            exp_done = zero_pending;
            zero_pending = 0;

            if (mem_write_m) begin
                chk("write_br", br, 1'b1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none", mem_address);
                end else begin
                    if (!first_wr_seen) begin
                        first_wr_addr = mem_address;
                        first_wr_seen = 1;
                    end
                    chk("mem_address", mem_address, exp_q[0]);
                    chk("dev_index", dev_index, exp_idx_q[0]);
                    chk("mem_data", mem_data, line_of(exp_idx_q[0], salt));
                    if (bg) begin
                        run++;
                        if (run == L) begin
                            void'(exp_q.pop_front());
                            void'(exp_idx_q.pop_front());
                            commits++;
                            run = 0;
                            if (exp_q.size() == 0) exp_done = 1;
                            else if (GAP != 0) exp_gap = 1;
                            else exp_next_write = 1;
                        end
                    end else begin
                        run = 0;
                        exp_drop = 1;
                    end
                end
            end else begin
                run = 0;
                chk("mem_data_zero", mem_data, 64'd0);
                if (br && bg) exp_enter = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int start_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n, input bit accepted);
        int nch;
        logic [ADDR_W-1:0] b;
        tick();
        dma_addr  = a;
        dma_len   = n;
        dma_start = 1'b1;
        if (accepted) begin
            nch = int'(n >> 2);
            b = {a[ADDR_W-1:2], 2'b00};
            for (int i = 0; i < nch; i++) begin
                exp_q.push_back(b + ADDR_W'(4 * i));
                exp_idx_q.push_back(IDX_W'(i));
            end
            if (nch == 0) zero_pending = 1;
            start_cyc = cyc;
        end
        tick();
        dma_start = 1'b0;
        dma_addr  = ADDR_W'($urandom);
        dma_len   = LEN_W'($urandom);
    endtask

    task automatic wait_done(input int bound, input bit random_bg);
        int d0;
        int k;
        d0 = done_pulses;
        k = 0;
        while (done_pulses == d0 && k < bound) begin
            tick();
            if (random_bg) bg = ($urandom_range(0, 99) < 75);
            k++;
        end
        if (done_pulses == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", bound);
        end
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_br"}, br, 1'b0);
        chk({tag, "_mw"}, mem_write_m, 1'b0);
        chk({tag, "_addr"}, mem_address, 64'd0);
        chk({tag, "_data"}, mem_data, 64'd0);
        chk({tag, "_idx"}, dev_index, 64'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, dma_done, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] exp_base;
        int                exp_n;
        int                exp_lat;  // cycles from command edge to dma_done, bg held high
    } vec_t;

    function automatic int lat_of(input int n);
        lat_of = (n == 0) ? 1 : n * L + 2 + GAP * (n - 1);
    endfunction

    vec_t vecs[6];

    initial begin
        int c0, d0, k;
        bit found;

        vecs[0] = '{16'h0018, 16'd12, 16'h0018, 3, lat_of(3)};
        vecs[1] = '{16'h0013, 16'd5,  16'h0010, 1, lat_of(1)};
        vecs[2] = '{16'h0000, 16'd3,  16'h0000, 0, lat_of(0)};
        vecs[3] = '{16'hFFFC, 16'd8,  16'hFFFC, 2, lat_of(2)};
        vecs[4] = '{16'h1235, 16'd17, 16'h1234, 4, lat_of(4)};
        vecs[5] = '{16'h0101, 16'd7,  16'h0100, 1, lat_of(1)};

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_outputs_zero("reset");
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Table: bg held high throughout.
        bg = 1'b1;
        foreach (vecs[i]) begin
            salt = {$urandom, $urandom};
            first_wr_seen = 0;
            c0 = commits;
            start_cmd(vecs[i].addr, vecs[i].len, 1'b1);
            wait_done(500, 1'b0);
            chk($sformatf("vec%0d_chunks", i), 64'(commits - c0), 64'(vecs[i].exp_n));
            chk($sformatf("vec%0d_latency", i), 64'(done_cyc - start_cyc), 64'(vecs[i].exp_lat));
            if (vecs[i].exp_n > 0)
                chk($sformatf("vec%0d_base", i), first_wr_addr, vecs[i].exp_base);
            tick();
        end

        // Basic burst with bg arriving two cycles after br.
        bg = 1'b0;
        c0 = commits;
        d0 = done_pulses;
        start_cmd(16'h0018, 16'd12, 1'b1);
        @(negedge clk);
        chk("br_after_start", br, 1'b1);
        chk("busy_after_start", busy, 1'b1);
        chk("no_write_before_grant", mem_write_m, 1'b0);
        tick();
        tick();
        bg = 1'b1;
        wait_done(500, 1'b0);
        chk("burst_chunks", 64'(commits - c0), 64'd3);
        chk("burst_done_once", 64'(done_pulses - d0), 64'd1);

        // Grant loss in cycle 2 of chunk 1.
        c0 = commits;
        d0 = done_pulses;
        start_cmd(16'h0018, 16'd12, 1'b1);
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (mem_write_m && mem_address == 16'h001C) found = 1;
        end
        chk("reach_chunk1", 64'(found), 64'd1);
        tick();
        bg = 1'b0;
        repeat (3) tick();
        bg = 1'b1;
        wait_done(500, 1'b0);
        chk("loss_chunks", 64'(commits - c0), 64'd3);
        chk("loss_done_once", 64'(done_pulses - d0), 64'd1);

        // Command pulsed while busy is ignored.
        bg = 1'b0;
        c0 = commits;
        first_wr_seen = 0;
        start_cmd(16'h0040, 16'd8, 1'b1);
        start_cmd(16'h0800, 16'd16, 1'b0);
        @(negedge clk);
        chk("busy_while_req", busy, 1'b1);
        tick();
        bg = 1'b1;
        wait_done(500, 1'b0);
        chk("busy_start_chunks", 64'(commits - c0), 64'd2);
        chk("busy_start_addr", first_wr_addr, 16'h0040);

        // Reset in the middle of a transfer.
        d0 = done_pulses;
        start_cmd(16'h0200, 16'd40, 1'b1);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_outputs_zero("midreset");
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("midreset_no_done", 64'(done_pulses - d0), 64'd0);

        // Randomized transfers with a flickering grant.
        for (int t = 0; t < 25; t++) begin
            salt = {$urandom, $urandom};
            d0 = done_pulses;
            start_cmd(ADDR_W'($urandom), LEN_W'($urandom_range(0, 44)), 1'b1);
            wait_done(3000, 1'b1);
            chk("rand_done_once", 64'(done_pulses - d0), 64'd1);
            k = $urandom_range(0, 3);
            repeat (k) tick();
        end
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
